// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter
//   Shares the single read port of the collision-map ROM among N_REQ
//   requesters. Each cycle a round-robin arbiter picks one pending request,
//   registers the grant and the ROM address, and follows the read through a
//   tag pipeline that matches the ROM latency. The datum comes back as a
//   registered broadcast on rsp_data, and a one-hot rsp_valid pulse marks the
//   requester that owns it.
//
//   Optional build macro: MAP_ARB_FIXED_PRIO_EN
//     defined   - requester 0 has fixed top priority. Requesters
//                 1..N_REQ-1 share round-robin when req[0] is low.
//     undefined - pure round-robin over all N_REQ requesters.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset, released synchronously
//   req        per-requester level request; held with a stable address until gnt
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        one-hot, one-cycle pulse: request accepted
//   rsp_valid  one-hot, one-cycle pulse: rsp_data belongs to requester i
//   rsp_data   read data broadcast to all requesters; holds between responses
//   rom_addr   ROM read address
//   rom_data   ROM read data, valid ROM_LAT cycles after rom_addr is registered
//   busy       high while a grant or any read is in flight
module map_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LAST  = ROM_LAT - 1;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] gnt_idx_p0;
  logic             tag_vld_p [ROM_LAT];
  logic [IDX_W-1:0] tag_idx_p [ROM_LAT];

  // Arbitration: first asserted request at or after rr_ptr, wrapping upward.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_i;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_i    = '0;
`ifdef MAP_ARB_FIXED_PRIO_EN
    begin
      int base;
      // rr_ptr never points at 0 in this mode except straight out of reset.
      base = (rr_ptr == '0) ? 1 : int'(rr_ptr);
      if (req[0]) begin
        win_found = 1'b1;
      end
      for (int k = 0; k < N_REQ - 1; k++) begin
        cand   = 1 + ((base - 1 + k) % (N_REQ - 1));
        cand_i = IDX_W'(cand);
        if (!win_found && req[cand_i]) begin
          win_found = 1'b1;
          win_idx   = cand_i;
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      cand   = (int'(rr_ptr) + k) % N_REQ;
      cand_i = IDX_W'(cand);
      if (!win_found && req[cand_i]) begin
        win_found = 1'b1;
        win_idx   = cand_i;
      end
    end
`endif
  end

  // Pointer advances past the winner. Grants to requester 0 under fixed
  // priority leave it untouched.
  always_comb begin
    ptr_nxt = rr_ptr;
`ifdef MAP_ARB_FIXED_PRIO_EN
    if (win_idx != '0) begin
      if (int'(win_idx) == N_REQ - 1) ptr_nxt = IDX_W'(1);
      else                            ptr_nxt = win_idx + IDX_W'(1);
    end
`else
    if (int'(win_idx) == N_REQ - 1) ptr_nxt = '0;
    else                            ptr_nxt = win_idx + IDX_W'(1);
`endif
  end

  always_comb begin
    busy = |gnt;
    for (int k = 0; k < ROM_LAT; k++) begin
      busy = busy | tag_vld_p[k];
    end
  end

  // Stage p0: grant and ROM address registered. The tag stages then follow
  // the read, and the response is captured one cycle after the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rom_addr  <= '0;
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        tag_vld_p[k] <= 1'b0;
      end
    end else begin
      gnt <= win_found ? onehot(win_idx) : '0;
      if (win_found) begin
        rom_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
        rr_ptr   <= ptr_nxt;
      end
      tag_vld_p[0] <= |gnt;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
      end
      rsp_valid <= tag_vld_p[LAST] ? onehot(tag_idx_p[LAST]) : '0;
      if (tag_vld_p[LAST]) begin
        rsp_data <= rom_data;
      end
    end
  end

  // Index payload only; its validity comes from gnt / tag_vld_p.
  always_ff @(posedge clk) begin
    gnt_idx_p0   <= win_idx;
    tag_idx_p[0] <= gnt_idx_p0;
    for (int k = 1; k < ROM_LAT; k++) begin
      tag_idx_p[k] <= tag_idx_p[k-1];
    end
  end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Shares the single read port of the 4-bit collision-map ROM among up to N_REQ game-logic requesters, e.g. player X probe, player Y probe and enemy probes.
- Performs round-robin arbitration, drives the ROM address, and tracks in-flight reads in a tag pipeline matching ROM read latency.
- Returns each read datum to the requester that issued it.
- Sits between the collision/movement logic and the map ROM port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, ROM address width.
- DATA_W, 4, ROM data width.
- ROM_LAT, 1, clock cycles from rom_addr registered to rom_data valid (1..3).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester read request, level.
- req_addr  input  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  output  N_REQ  one-hot, one-cycle pulse: request accepted this cycle.
- rsp_valid  output  N_REQ  one-hot, one-cycle pulse: rsp_data belongs to requester i.
- rsp_data  output  DATA_W  read data, broadcast to all requesters.
- rom_addr  output  ADDR_W  address to the ROM read port.
- rom_data  input  DATA_W  ROM read data.
- busy  output  1  high while any read is in flight.

Behaviour:
- Reset (async assert, sync release) clears the following to 0:
  - gnt, rsp_valid, rsp_data, rom_addr, busy.
  - Tag pipeline valid bits.
  - RR pointer.
- Handshake:
  - Requester holds req=1 and a stable address until it sees gnt.
  - Deasserting req before gnt withdraws the request, legal, no response.
  - New req in the cycle after gnt starts a new transaction.
- Arbitration each cycle, combinational over req:
  - Winner is the first asserted req at or after rr_ptr, searching upward with wrap N_REQ-1 -> 0.
  - On the next edge: gnt[winner] registered high, rom_addr registered to the winner's address, rr_ptr <= (winner+1) mod N_REQ.
  - No req: gnt=0, rom_addr holds its last value, rr_ptr unchanged.
- Throughput: one grant per cycle, fully pipelined, no stall; the ROM always accepts.
- Tag pipeline:
  - ROM_LAT stages of {valid, idx[$clog2(N_REQ)-1:0]}.
  - Stage 0 loads {1, winner} on a grant cycle, otherwise {0, x}.
- Response:
  - Sampled one cycle after the last stage, so rsp_data is registered from rom_data.
  - Latency from gnt high to rsp_valid high = ROM_LAT+1 cycles.
  - rsp_valid[idx] pulses for exactly one cycle; rsp_data holds until the next response.
- busy = OR of all tag valid bits, plus gnt.
- Boundaries:
  - A requester may be regranted every cycle when it alone requests.
  - With all requesters asserting, each is granted once per N_REQ cycles.
  - Reset mid-flight drops all pending responses; no rsp_valid after release until new grants.
  - Address values are passed unchecked; ROM wrap is the ROM's concern.

Optional Feature:
- Macro: MAP_ARB_FIXED_PRIO_EN.
- Defined: requester 0 has fixed top priority and is granted whenever req[0]=1. The remaining requesters are round-robin among themselves when req[0]=0, and rr_ptr ignores index 0.
- Undefined: pure round-robin over all N_REQ as above.

Test Plan:
- Reset check: hold rst_n=0, toggle req=4'b1111 -> gnt, rsp_valid, rom_addr, busy stay 0; after release, first gnt=4'b0001.
- Single request, ROM_LAT=1: req[2]=1, addr2=16'h0123, ROM model returns 4'hA -> gnt=4'b0100, rom_addr=16'h0123; rsp_valid=4'b0100 with rsp_data=4'hA exactly 2 cycles later.
- All four requesting continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Each rsp_valid appears 2 cycles after its gnt.
  - Data matches the ROM model for that requester's address.
- Withdraw: req[1]=1 while req[0] is granted, then req[1]=0 before its turn -> gnt[1] never pulses, no rsp_valid[1].
- Reset mid-flight: assert rst_n=0 one cycle after a gnt -> no rsp_valid for that grant; busy=0 after release.
- MAP_ARB_FIXED_PRIO_EN defined, req=4'b1011 held -> gnt[0] every cycle; after req[0] drops, gnt alternates 0010, 1000.
